// File: rtl/fxp_segpoly_eval.sv
// Multi-channel pipelined piecewise-quadratic evaluator: Z = ((a*d + b)*d) + c per segment, 7-cycle latency.
// Optional build macro FXP_SEGPOLY_SAT_EN selects output saturation instead of wrap-around.
module fxp_segpoly_eval #(
    parameter int W        = 32,
    parameter int SEG_BITS = 6,
    parameter int CW       = 32,
    parameter int NCH      = 2,
    localparam int CH_BITS = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          pushin,
    input  logic [CH_BITS-1:0]            ch,
    input  logic [W-1:0]                  U,
    input  logic                          cfg_we,
    input  logic [CH_BITS+SEG_BITS+1:0]   cfg_addr,
    input  logic [CW-1:0]                 cfg_wdata,
    input  logic                          clr_ovf,
    output logic                          pushout,
    output logic [CH_BITS-1:0]            ch_out,
    output logic [CW-1:0]                 Z,
    output logic                          ovf
);

    localparam int D    = W - SEG_BITS;
    localparam int NSEG = 1 << SEG_BITS;
    localparam int AW   = CH_BITS + SEG_BITS + 2;
    localparam int PW1  = CW + D + 1;
    localparam int PW2  = CW + D + 2;
    localparam logic [CH_BITS:0] NCH_W = (CH_BITS + 1)'(NCH);

    logic [CW-1:0] tab_a [NCH][NSEG];
    logic [CW-1:0] tab_b [NCH][NSEG];
    logic [CW-1:0] tab_c [NCH][NSEG];

    logic [CH_BITS-1:0]  wr_ch;
    logic [SEG_BITS-1:0] wr_seg;
    logic [1:0]          wr_sel;
    logic                wr_ok;

    logic                s0_valid;
    logic [CH_BITS-1:0]  s0_ch;
    logic [SEG_BITS-1:0] s0_idx;
    logic [D-1:0]        s0_delta;

    logic                s1_valid;
    logic [CH_BITS-1:0]  s1_ch;
    logic [D-1:0]        s1_delta;
    logic [CW-1:0]       s1_a, s1_b, s1_c;

    logic                s2_valid;
    logic [CH_BITS-1:0]  s2_ch;
    logic [D-1:0]        s2_delta;
    logic [CW-1:0]       s2_p1, s2_b, s2_c;

    logic                s3_valid;
    logic [CH_BITS-1:0]  s3_ch;
    logic [D-1:0]        s3_delta;
    logic [CW:0]         s3_s1;
    logic [CW-1:0]       s3_c;

    logic                s4_valid;
    logic [CH_BITS-1:0]  s4_ch;
    logic [CW:0]         s4_p2;
    logic [CW-1:0]       s4_c;

    logic                s5_valid;
    logic [CH_BITS-1:0]  s5_ch;
    logic [CW+1:0]       s5_r;

    logic [CH_BITS-1:0]  rd_ch;
    logic [PW1-1:0]      prod1;
    logic [CW-1:0]       p1_calc;
    logic [CW:0]         s1_calc;
    logic [PW2-1:0]      prod2;
    logic [CW:0]         p2_calc;
    logic [CW+1:0]       r_calc;
    logic                r_ovf;
    logic [CW-1:0]       z_next;
    logic                unused_prod_bits;

    assign wr_ch  = cfg_addr[AW-1 -: CH_BITS];
    assign wr_seg = cfg_addr[2 +: SEG_BITS];
    assign wr_sel = cfg_addr[1:0];
    assign wr_ok  = cfg_we && ({1'b0, wr_ch} < NCH_W);

    // Coefficient tables live in flops so reset can clear every entry
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < NCH; c++) begin
                for (int s = 0; s < NSEG; s++) begin
                    tab_a[c][s] <= '0;
                    tab_b[c][s] <= '0;
                    tab_c[c][s] <= '0;
                end
            end
        end else if (wr_ok) begin
            case (wr_sel)
                2'd0:    tab_a[wr_ch][wr_seg] <= cfg_wdata;
                2'd1:    tab_b[wr_ch][wr_seg] <= cfg_wdata;
                2'd2:    tab_c[wr_ch][wr_seg] <= cfg_wdata;
                default: ;
            endcase
        end
    end

    // Out-of-range channels fall back to table 0
    assign rd_ch = ({1'b0, s0_ch} < NCH_W) ? s0_ch : '0;

    // Products are formed at full width with explicit extension; the slice is the floor shift
    assign prod1   = {{(D+1){s1_a[CW-1]}}, s1_a} * {{(CW+1){1'b0}}, s1_delta};
    assign p1_calc = prod1[D +: CW];
    assign s1_calc = {s2_p1[CW-1], s2_p1} + {s2_b[CW-1], s2_b};
    assign prod2   = {{(D+1){s3_s1[CW]}}, s3_s1} * {{(CW+2){1'b0}}, s3_delta};
    assign p2_calc = prod2[D +: CW+1];
    assign r_calc  = {s4_p2[CW], s4_p2} + {{2{s4_c[CW-1]}}, s4_c};

    assign unused_prod_bits = ^{prod1[PW1-1], prod1[D-1:0], prod2[PW2-1], prod2[D-1:0]};

    assign r_ovf = !((s5_r[CW+1:CW-1] == 3'b000) || (s5_r[CW+1:CW-1] == 3'b111));

`ifdef FXP_SEGPOLY_SAT_EN
    assign z_next = r_ovf ? (s5_r[CW+1] ? {1'b1, {(CW-1){1'b0}}} : {1'b0, {(CW-1){1'b1}}})
                          : s5_r[CW-1:0];
`else
    assign z_next = s5_r[CW-1:0];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s0_valid <= 1'b0;
            s0_ch    <= '0;
            s0_idx   <= '0;
            s0_delta <= '0;
            s1_valid <= 1'b0;
            s1_ch    <= '0;
            s1_delta <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_c     <= '0;
            s2_valid <= 1'b0;
            s2_ch    <= '0;
            s2_delta <= '0;
            s2_p1    <= '0;
            s2_b     <= '0;
            s2_c     <= '0;
        end else begin
            s0_valid <= pushin;
            s0_ch    <= ch;
            s0_idx   <= U[W-1 -: SEG_BITS];
            s0_delta <= U[D-1:0];
            s1_valid <= s0_valid;
            s1_ch    <= s0_ch;
            s1_delta <= s0_delta;
            s1_a     <= tab_a[rd_ch][s0_idx];
            s1_b     <= tab_b[rd_ch][s0_idx];
            s1_c     <= tab_c[rd_ch][s0_idx];
            s2_valid <= s1_valid;
            s2_ch    <= s1_ch;
            s2_delta <= s1_delta;
            s2_p1    <= p1_calc;
            s2_b     <= s1_b;
            s2_c     <= s1_c;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s3_valid <= 1'b0;
            s3_ch    <= '0;
            s3_delta <= '0;
            s3_s1    <= '0;
            s3_c     <= '0;
            s4_valid <= 1'b0;
            s4_ch    <= '0;
            s4_p2    <= '0;
            s4_c     <= '0;
            s5_valid <= 1'b0;
            s5_ch    <= '0;
            s5_r     <= '0;
        end else begin
            s3_valid <= s2_valid;
            s3_ch    <= s2_ch;
            s3_delta <= s2_delta;
            s3_s1    <= s1_calc;
            s3_c     <= s2_c;
            s4_valid <= s3_valid;
            s4_ch    <= s3_ch;
            s4_p2    <= p2_calc;
            s4_c     <= s3_c;
            s5_valid <= s4_valid;
            s5_ch    <= s4_ch;
            s5_r     <= r_calc;
        end
    end

    // Z and ch_out only move on valid results; ovf set has priority over clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pushout <= 1'b0;
            ch_out  <= '0;
            Z       <= '0;
            ovf     <= 1'b0;
        end else begin
            pushout <= s5_valid;
            if (s5_valid) begin
                ch_out <= s5_ch;
                Z      <= z_next;
            end
            if (s5_valid && r_ovf) begin
                ovf <= 1'b1;
            end else if (clr_ovf) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: doc/fxp_segpoly_eval.md
Name: fxp_segpoly_eval

Overview:
- Parametrised, multi-channel, pipelined piecewise-quadratic function evaluator for the random-distribution datapath.
- Successor to the fixed sqrt-ln / sin lookup-plus-interpolation stage: generalised in width, segment count and channel count (one function table per channel).
- Coefficient tables are loadable at run time; output saturation is optional.
- Accepts one sample per cycle on pushin and returns one result per cycle on pushout after a fixed latency.

Parameters:
W, 32, input sample width; unsigned Q0.W fraction in [0,1)
SEG_BITS, 6, segment index width; 2^SEG_BITS segments per channel
CW, 32, coefficient and result width; signed two's complement
NCH, 2, number of channels (function tables); CH_BITS = clog2(NCH), minimum 1

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous, active-low reset
pushin  in  1  sample valid
ch  in  CH_BITS  channel select for the sample
U  in  W  sample
cfg_we  in  1  coefficient write strobe
cfg_addr  in  CH_BITS+SEG_BITS+2  {channel, segment, sel}; sel 0=a, 1=b, 2=c, 3=ignored
cfg_wdata  in  CW  coefficient value
clr_ovf  in  1  clears the ovf flag
pushout  out  1  result valid
ch_out  out  CH_BITS  channel of the result
Z  out  CW  result
ovf  out  1  sticky overflow flag

Behaviour:
- Reset (rst low, asynchronous):
  - Clear all pipeline valid bits, data registers, every table entry, pushout, ch_out, Z and ovf to 0.
  - Drop in-flight samples; none emerge after rst is released.
- Field split:
  - idx = U[W-1 -: SEG_BITS].
  - delta = U[W-SEG_BITS-1:0], D = W-SEG_BITS bits, unsigned.
- Pipeline (one stage per cycle, no backpressure):
  - S0: register pushin, ch, idx, delta.
  - S1: read a, b, c for {ch, idx}; register them.
  - S2: p1 = (a * delta) >>> D (delta zero-extended, arithmetic shift, truncates toward -inf).
  - S3: s1 = p1 + b, CW+1 bits.
  - S4: p2 = (s1 * delta) >>> D, CW+1 bits.
  - S5: r = p2 + c, CW+2 bits; reduce to CW bits per the optional feature.
  - Register Z, ch_out and pushout = S5 valid.
- Latency: a sample with pushin high at edge N produces pushout high in the cycle after edge N+6.
- Throughput: one sample per cycle; order preserved. Bubbles propagate as pushout low; Z holds its last value when pushout is low.
- Table writes:
  - cfg_we high at an edge writes the addressed entry; sel=3 is a no-op.
  - A write and an S1 read of the same entry at the same edge: the sample uses the old value. Samples reading at later edges use the new value.
  - Writes are independent of pushin and may occur every cycle.
- ch >= NCH: the sample reads channel 0 and ch_out echoes the raw ch value.
- ovf:
  - Set at the S5 edge when r is not representable in CW bits and the S5 stage is valid.
  - clr_ovf clears it. Simultaneous set and clr_ovf: set wins.
  - ovf is independent of the optional feature.

Optional Feature:
- FXP_SEGPOLY_SAT_EN defined: an out-of-range r saturates Z to 2^(CW-1)-1 or -2^(CW-1).
- FXP_SEGPOLY_SAT_EN undefined: Z = r[CW-1:0] (wrap-around).
- Latency is identical in both builds.

Test Plan:
- Constant: ch0 seg0 a=0, b=0, c=5; pushin with ch=0, U=0x00000000 -> exactly 6 cycles later pushout=1, ch_out=0, Z=5, ovf=0.
- Linear: ch1 seg3 a=0, b=0x00100000, c=0; U={6'd3, 26'h2000000} -> Z=0x00080000, ch_out=1.
- Quadratic: ch0 seg1 a=0x04000000, b=0, c=0; U={6'd1, 26'h2000000} -> Z=0x01000000.
- Overflow: ch0 seg2 a=0, b=c=0x7FFFFFFF; U={6'd2, 26'h3FFFFFF} -> ovf=1.
  - With FXP_SEGPOLY_SAT_EN: Z=0x7FFFFFFF.
  - Without it: Z=0xFFFFFFDE.
  - Then clr_ovf=1 for one cycle -> ovf=0.
- Streaming and hazard:
  - 100 back-to-back samples alternating ch0/ch1 -> 100 contiguous pushouts in order after 6 cycles, each Z matching the reference model.
  - Writing c of an entry at the same edge as its S1 read -> that sample uses the old c; the next sample uses the new c.
- Reset mid-stream: drive rst low for one cycle while 4 samples are in flight -> pushout=0 immediately and stays 0 until new pushin plus 6 cycles; tables read as 0 (Z=0).
